// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: request op codes, instruction opcode fields and loader states.
package legv8_pkg;

    typedef enum logic [2:0] {
        OP_LDUR = 3'd0,
        OP_STUR = 3'd1,
        OP_CBZ  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_AND  = 3'd5,
        OP_ORR  = 3'd6,
        OP_ILL  = 3'd7
    } op_e;

    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational field packer: turns an op plus register/immediate fields into a 32-bit LEGv8 word.
module instr_encoder
    import legv8_pkg::*;
(
    input  op_e         op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rn_i,
    input  logic [4:0]  rm_i,
    input  logic [18:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = 32'h0000_0000;
        illegal_o = 1'b0;
        case (op_i)
            OP_LDUR: word_o = {OPC_LDUR, imm_i[8:0], 2'b00, rn_i, rd_i};
            OP_STUR: word_o = {OPC_STUR, imm_i[8:0], 2'b00, rn_i, rd_i};
            OP_CBZ:  word_o = {OPC_CBZ, imm_i, rd_i};
            OP_ADD:  word_o = {OPC_ADD, rm_i, 6'b000000, rn_i, rd_i};
            OP_SUB:  word_o = {OPC_SUB, rm_i, 6'b000000, rn_i, rd_i};
            OP_AND:  word_o = {OPC_AND, rm_i, 6'b000000, rn_i, rd_i};
            OP_ORR:  word_o = {OPC_ORR, rm_i, 6'b000000, rn_i, rd_i};
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Session-based instruction loader: accepts encode requests, packs them and writes
// consecutive words into instruction memory through a registered write port.
module instr_loader
    import legv8_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          finish,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [4:0]    rd,
    input  logic [4:0]    rn,
    input  logic [4:0]    rm,
    input  logic [18:0]   imm,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          full,
    output logic          err,
    output logic [AW:0]   count
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;

    logic [31:0]   enc_word;
    logic          enc_illegal;
    logic          xfer;

    instr_encoder u_enc (
        .op_i      (op_e'(op)),
        .rd_i      (rd),
        .rn_i      (rn),
        .rm_i      (rm),
        .imm_i     (imm),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    assign in_ready = (state_q == ST_LOAD);
    assign xfer     = in_valid && in_ready;

    // A transfer accepted alongside finish still lands its write; finish only steers the state.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (xfer) begin
            we_d    = 1'b1;
            waddr_d = count_q[AW-1:0];
            wdata_d = enc_word;
            count_d = count_q + 1'b1;
            if (enc_illegal) begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end else if (xfer && (count_q == LAST_IDX)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign full       = (state_q == ST_FULL);
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader with hand-computed encodings and session behaviour.
module tb_instr_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [4:0]    rd;
    logic [4:0]    rn;
    logic [4:0]    rm;
    logic [18:0]   imm;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          full;
    logic          err;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .finish     (finish),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .rd         (rd),
        .rn         (rn),
        .rm         (rm),
        .imm        (imm),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .full       (full),
        .err        (err),
        .count      (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] o, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic [18:0] im);
        in_valid = 1'b1;
        op       = o;
        rd       = d;
        rn       = n;
        rm       = m;
        imm      = im;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        op = 3'd0; rd = 5'd0; rn = 5'd0; rm = 5'd0; imm = 19'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", imem_wdata, 32'h0000_0000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);

        // Idle ignores requests
        req(3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
        step();
        in_valid = 1'b0;
        check("idle_no_we", 32'(imem_we), 32'd0);

        // ADD X3, X1, X2
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_count", 32'(count), 32'd0);
        req(3'd3, 5'd3, 5'd1, 5'd2, 19'd0);
        step();
        in_valid = 1'b0;
        check("add_we", 32'(imem_we), 32'd1);
        check("add_waddr", 32'(imem_waddr), 32'd0);
        check("add_wdata", imem_wdata, 32'h8B02_0023);
        check("add_count", 32'(count), 32'd1);
        step();
        check("add_we_drop", 32'(imem_we), 32'd0);
        pulse_finish();
        check("fin_busy", 32'(busy), 32'd0);
        check("fin_count_hold", 32'(count), 32'd1);

        // LDUR then CBZ back to back
        pulse_start();
        check("restart_count", 32'(count), 32'd0);
        req(3'd0, 5'd2, 5'd1, 5'd0, 19'd8);
        step();
        check("ldur_we", 32'(imem_we), 32'd1);
        check("ldur_waddr", 32'(imem_waddr), 32'd0);
        check("ldur_wdata", imem_wdata, 32'hF840_8022);
        req(3'd2, 5'd5, 5'd0, 5'd0, 19'd3);
        step();
        in_valid = 1'b0;
        check("cbz_we", 32'(imem_we), 32'd1);
        check("cbz_waddr", 32'(imem_waddr), 32'd1);
        check("cbz_wdata", imem_wdata, 32'hB400_0065);
        step();
        check("cbz_we_drop", 32'(imem_we), 32'd0);
        check("cbz_count", 32'(count), 32'd2);
        pulse_finish();

        // Fill to capacity
        pulse_start();
        for (int i = 0; i < DEPTH; i++) begin
            req(3'd3, 5'(i), 5'd1, 5'd2, 19'd0);
            step();
            check("fill_we", 32'(imem_we), 32'd1);
            check("fill_waddr", 32'(imem_waddr), 32'(i));
            check("fill_wdata", imem_wdata, 32'h8B02_0020 | 32'(i % 32));
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        check("full_count", 32'(count), 32'd64);
        step();
        in_valid = 1'b0;
        check("full_no_we", 32'(imem_we), 32'd0);
        check("full_waddr_hold", 32'(imem_waddr), 32'd63);
        check("full_count_hold", 32'(count), 32'd64);
        pulse_start();
        check("full_start_ignored", 32'(full), 32'd1);
        pulse_finish();
        check("full_fin_full", 32'(full), 32'd0);
        check("full_fin_busy", 32'(busy), 32'd0);

        // Illegal op
        pulse_start();
        req(3'd7, 5'd9, 5'd9, 5'd9, 19'h7FFFF);
        step();
        check("ill_we", 32'(imem_we), 32'd1);
        check("ill_wdata", imem_wdata, 32'h0000_0000);
        check("ill_err", 32'(err), 32'd1);
        req(3'd4, 5'd3, 5'd1, 5'd2, 19'd0);
        step();
        in_valid = 1'b0;
        check("sub_waddr", 32'(imem_waddr), 32'd1);
        check("sub_wdata", imem_wdata, 32'hCB02_0023);
        check("ill_err_sticky", 32'(err), 32'd1);
        pulse_finish();
        check("ill_err_idle", 32'(err), 32'd1);
        pulse_start();
        check("ill_err_clear", 32'(err), 32'd0);

        // start+finish with transfer in the same cycle
        start = 1'b1; finish = 1'b1;
        req(3'd6, 5'd3, 5'd1, 5'd2, 19'd0);
        step();
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        check("sf_we", 32'(imem_we), 32'd1);
        check("sf_waddr", 32'(imem_waddr), 32'd0);
        check("sf_wdata", imem_wdata, 32'hAA02_0023);
        check("sf_busy", 32'(busy), 32'd0);
        check("sf_ready", 32'(in_ready), 32'd0);
        check("sf_count", 32'(count), 32'd1);

        // Reset during an accepted transfer
        pulse_start();
        req(3'd7, 5'd0, 5'd0, 5'd0, 19'd0);
        step();
        req(3'd5, 5'd3, 5'd1, 5'd2, 19'd0);
        step();
        check("pre_rst_wdata", imem_wdata, 32'h8A02_0023);
        check("pre_rst_err", 32'(err), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        check("mrst_we", 32'(imem_we), 32'd0);
        check("mrst_waddr", 32'(imem_waddr), 32'd0);
        check("mrst_wdata", imem_wdata, 32'h0000_0000);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_full", 32'(full), 32'd0);
        check("mrst_err", 32'(err), 32'd0);
        check("mrst_count", 32'(count), 32'd0);
        step();
        check("mrst_we_after", 32'(imem_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
